// File: rtl/e203_demo_pkg.sv
// Shared constants and state encodings for the e203 board demo top.
// Video timing is CEA 480p on a 27 MHz pixel clock.
package e203_demo_pkg;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_ACTIVE = 720;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 62;
  localparam int unsigned H_TOTAL  = 858;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 9;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_TOTAL  = 525;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

endpackage

// File: rtl/demo_uart.sv
// 8N1 UART receiver with a transmitter that echoes each received byte.
// A byte that arrives while the transmitter is busy is reported but not echoed.
module demo_uart
  import e203_demo_pkg::*;
#(
  parameter int unsigned DIV = 234
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic            r_rx_s1, r_rx_s2, r_rx_d;
  rx_state_e       r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]   r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]      r_rx_bit, w_rx_bit_nxt;
  logic [7:0]      r_rx_sh, w_rx_sh_nxt;
  logic            r_valid, w_valid_nxt;
  logic [7:0]      r_data, w_data_nxt;

  tx_state_e       r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]   r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]      r_tx_bit, w_tx_bit_nxt;
  logic [7:0]      r_tx_sh, w_tx_sh_nxt;
  logic            r_tx, w_tx_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_d     <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_valid    <= w_valid_nxt;
      r_data     <= w_data_nxt;
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Receiver: start re-checked mid-bit, then bits sampled at their centres.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CW'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_sh_nxt    = r_rx_sh;
    w_valid_nxt    = 1'b0;
    w_data_nxt     = r_data;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_d && !r_rx_s2) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == CW'(DIV / 2 - 1)) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CW'(DIV - 1)) begin
          w_rx_cnt_nxt = '0;
          w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CW'(DIV - 1)) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_s2) begin
            w_valid_nxt    = 1'b1;
            w_data_nxt     = r_rx_sh;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Transmitter: the line value for each bit is registered at the bit boundary.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_nxt       = r_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (r_valid) begin
          w_tx_sh_nxt    = r_data;
          w_tx_nxt       = 1'b0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (r_tx_cnt == CW'(DIV - 1)) begin
          w_tx_cnt_nxt   = '0;
          w_tx_nxt       = r_tx_sh[0];
          w_tx_sh_nxt    = {1'b0, r_tx_sh[7:1]};
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == CW'(DIV - 1)) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_nxt       = 1'b1;
            w_tx_state_nxt = TX_STOP;
          end else begin
            w_tx_nxt     = r_tx_sh[0];
            w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
            w_tx_bit_nxt = r_tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == CW'(DIV - 1)) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign o_tx    = r_tx;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/e203_soc_demo_top.sv
// Board demo top: 480p VGA fill-colour generator whose colour is set by three UART bytes,
// bound to the e203 SoC pad set with unused pads tied inactive.
module e203_soc_demo_top
  import e203_demo_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 27_000_000,
  parameter int unsigned BAUD    = 115_200,
  parameter int unsigned V_ACT    = V_ACTIVE,
  parameter int unsigned V_FPORCH = V_FP,
  parameter int unsigned V_SW     = V_SYNC,
  parameter int unsigned V_TOT    = V_TOTAL
) (
  input  logic        clk_in,
  input  logic        erst,
  output logic        H_sync,
  output logic        V_sync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  input  logic [3:0]  qspi_in,
  output logic [3:0]  qspi_out,
  output logic        qspi_sck,
  output logic        qspi_cs,
  input  logic        dbgmode0_n,
  input  logic        dbgmode1_n,
  input  logic        dbgmode3_n,
  input  logic        bootrom_n,
  input  logic        aon_pmu_dwakeup_n,
  output logic        aon_pmu_padrst,
  output logic        aon_pmu_vddpaden
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = CNT_W;

  logic [CW-1:0] r_h, r_v;
  logic [3:0]    r_pend_r, r_pend_g, r_pend_b;
  logic [3:0]    r_disp_r, r_disp_g, r_disp_b;
  logic [1:0]    r_idx;
  logic          w_hs_act, w_vs_act, w_active, w_frame_start;
  logic [3:0]    w_col_r, w_col_g, w_col_b;
  logic          w_rx_valid, w_tx;
  logic [7:0]    w_rx_data;
  logic          w_unused;

  demo_uart #(.DIV(DIV)) u_uart (
    .i_clk   (clk_in),
    .i_rst   (erst),
    .i_rx    (gpio_in[16]),
    .o_tx    (w_tx),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  assign w_hs_act = (r_h >= CW'(H_ACTIVE + H_FP)) && (r_h <= CW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign w_vs_act = (r_v >= CW'(V_ACT + V_FPORCH)) && (r_v <= CW'(V_ACT + V_FPORCH + V_SW - 1));
  assign w_active = (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACT));
  assign w_frame_start = (r_h == '0) && (r_v == '0);

  // The first pixel of a frame already shows the colour latched at that frame start.
  assign w_col_r = w_frame_start ? r_pend_r : r_disp_r;
  assign w_col_g = w_frame_start ? r_pend_g : r_disp_g;
  assign w_col_b = w_frame_start ? r_pend_b : r_disp_b;

  // Raster counters and registered sync/colour outputs.
  always_ff @(posedge clk_in or posedge erst) begin
    if (erst) begin
      r_h    <= '0;
      r_v    <= '0;
      H_sync <= 1'b1;
      V_sync <= 1'b1;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      if (r_h == CW'(H_TOTAL - 1)) begin
        r_h <= '0;
        r_v <= (r_v == CW'(V_TOT - 1)) ? '0 : r_v + CW'(1);
      end else begin
        r_h <= r_h + CW'(1);
      end
      H_sync <= ~w_hs_act;
      V_sync <= ~w_vs_act;
      red    <= w_active ? w_col_r : 4'h0;
      green  <= w_active ? w_col_g : 4'h0;
      blue   <= w_active ? w_col_b : 4'h0;
    end
  end

  // Received bytes fill pending R, G, B in turn; displayed copy updates only at frame start.
  always_ff @(posedge clk_in or posedge erst) begin
    if (erst) begin
      r_pend_r <= '0;
      r_pend_g <= '0;
      r_pend_b <= '0;
      r_disp_r <= '0;
      r_disp_g <= '0;
      r_disp_b <= '0;
      r_idx    <= '0;
    end else begin
      if (w_rx_valid) begin
        case (r_idx)
          2'd0:    r_pend_r <= w_rx_data[7:4];
          2'd1:    r_pend_g <= w_rx_data[7:4];
          default: r_pend_b <= w_rx_data[7:4];
        endcase
        r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end
      if (w_frame_start) begin
        r_disp_r <= r_pend_r;
        r_disp_g <= r_pend_g;
        r_disp_b <= r_pend_b;
      end
    end
  end

  assign gpio_out         = {14'h0, w_tx, 17'h0};
  assign tdo              = 1'b0;
  assign qspi_out         = 4'h0;
  assign qspi_sck         = 1'b0;
  assign qspi_cs          = 1'b1;
  assign aon_pmu_padrst   = erst;
  assign aon_pmu_vddpaden = 1'b1;

  assign w_unused = &{1'b0, gpio_in[31:17], gpio_in[15:0], tck, tms, tdi, qspi_in,
                      dbgmode0_n, dbgmode1_n, dbgmode3_n, bootrom_n, aon_pmu_dwakeup_n,
                      w_rx_data[3:0]};

endmodule

// File: tb/tb_e203_soc_demo_top.sv
// Bench for e203_soc_demo_top: sync timing, UART colour programming and echo,
// glitch/framing-error rejection and mid-byte reset. Frame height is shortened.
`timescale 1ns/1ps
module tb_e203_soc_demo_top;

  localparam int unsigned CLK_HZ = 27_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned DIV    = 234;
  localparam int unsigned HT     = 858;
  localparam int unsigned VA     = 1;
  localparam int unsigned VF     = 1;
  localparam int unsigned VS     = 2;
  localparam int unsigned VT     = 5;

  logic        clk_in = 1'b0;
  logic        erst;
  logic        H_sync, V_sync;
  logic [3:0]  red, green, blue;
  logic [31:0] gpio_in, gpio_out;
  logic        tck, tms, tdi, tdo;
  logic [3:0]  qspi_in, qspi_out;
  logic        qspi_sck, qspi_cs;
  logic        dbgmode0_n, dbgmode1_n, dbgmode3_n, bootrom_n, aon_pmu_dwakeup_n;
  logic        aon_pmu_padrst, aon_pmu_vddpaden;

  int checks   = 0;
  int failures = 0;

  always #18.518 clk_in = ~clk_in;

  e203_soc_demo_top #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .V_ACT(VA), .V_FPORCH(VF), .V_SW(VS), .V_TOT(VT)
  ) dut (
    .clk_in(clk_in), .erst(erst), .H_sync(H_sync), .V_sync(V_sync),
    .red(red), .green(green), .blue(blue), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .qspi_in(qspi_in), .qspi_out(qspi_out),
    .qspi_sck(qspi_sck), .qspi_cs(qspi_cs), .dbgmode0_n(dbgmode0_n), .dbgmode1_n(dbgmode1_n),
    .dbgmode3_n(dbgmode3_n), .bootrom_n(bootrom_n), .aon_pmu_dwakeup_n(aon_pmu_dwakeup_n),
    .aon_pmu_padrst(aon_pmu_padrst), .aon_pmu_vddpaden(aon_pmu_vddpaden)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        echo;
    logic        chk;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(negedge clk_in);
    gpio_in[16] = 1'b0;
    repeat (DIV) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      gpio_in[16] = d[i];
      repeat (DIV) @(negedge clk_in);
    end
    gpio_in[16] = stop_bit;
    repeat (DIV) @(negedge clk_in);
    gpio_in[16] = 1'b1;
    repeat (DIV) @(negedge clk_in);
  endtask

  // Waits for an echo start bit, then samples every bit at its centre.
  task automatic capture(output logic got, output logic [7:0] d, output int start_len,
                         output logic stop_ok);
    int k;
    got = 1'b0; d = '0; start_len = 0; stop_ok = 1'b0;
    for (int n = 0; n < int'(11 * DIV); n++) begin
      tick();
      if (gpio_out[17] == 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      for (int c = 1; c <= int'(9 * DIV + DIV / 2); c++) begin
        tick();
        if (start_len == 0 && gpio_out[17]) start_len = c;
        if (c >= int'(DIV + DIV / 2) && c <= int'(8 * DIV + DIV / 2) &&
            ((c - int'(DIV / 2)) % int'(DIV)) == 0) begin
          k = (c - int'(DIV / 2)) / int'(DIV);
          d[k - 1] = gpio_out[17];
        end
      end
      stop_ok = gpio_out[17];
    end
  endtask

  // Waits past the next frame start, then checks an active pixel and two blanked pixels.
  task automatic check_colour(input string name, input logic [11:0] exp);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < int'(VT * HT + 10); n++) begin
      tick();
      if (!V_sync) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_vsync_seen"}, 32'(seen), 32'd1);
    for (int n = 0; n < int'(VS * HT + 10); n++) begin
      tick();
      if (V_sync) break;
    end
    repeat ((VT - VA - VF - VS) * HT + 100) tick();
    check({name, "_active"}, 32'({red, green, blue}), 32'(exp));
    repeat (650) tick();
    check({name, "_hblank"}, 32'({red, green, blue}), 32'd0);
    repeat (HT - 650) tick();
    check({name, "_vblank"}, 32'({red, green, blue}), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_hsync"}, 32'(H_sync), 32'd1);
    check({name, "_vsync"}, 32'(V_sync), 32'd1);
    check({name, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({name, "_gpio_out"}, gpio_out, 32'h0002_0000);
    check({name, "_padrst"}, 32'(aon_pmu_padrst), 32'd1);
  endtask

  initial begin
    #6ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       got, stp, seen;
    logic [7:0] cap;
    int         slen, len;

    vecs[0] = '{8'hF0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[1] = '{8'h80, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[2] = '{8'h1F, 1'b1, 1'b1, 1'b1, 12'hF81};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 12'h381};

    erst = 1'b1;
    gpio_in = 32'hFFFF_FFFF;
    tck = 1'b0; tms = 1'b1; tdi = 1'b1; qspi_in = 4'hF;
    dbgmode0_n = 1'b1; dbgmode1_n = 1'b1; dbgmode3_n = 1'b1; bootrom_n = 1'b1;
    aon_pmu_dwakeup_n = 1'b1;

    repeat (10) tick();
    check_reset_outputs("reset");
    check("tieoffs", 32'({tdo, qspi_out, qspi_sck, qspi_cs, aon_pmu_vddpaden}), 32'b0_0000_0_1_1);
    repeat (8640 - 10) tick();
    @(negedge clk_in);
    erst = 1'b0;
    tick();
    check("padrst_released", 32'(aon_pmu_padrst), 32'd0);
    check("idle_gpio_out", gpio_out, 32'h0002_0000);

    // Horizontal sync: low width and period.
    seen = 1'b0;
    for (int n = 0; n < int'(HT + 10); n++) begin
      tick();
      if (!H_sync) begin seen = 1'b1; break; end
    end
    check("hsync_seen", 32'(seen), 32'd1);
    len = 0;
    for (int n = 0; n < int'(HT); n++) begin
      tick(); len++;
      if (H_sync) break;
    end
    check("hsync_low_width", 32'(len), 32'd62);
    for (int n = 0; n < int'(HT); n++) begin
      tick(); len++;
      if (!H_sync) break;
    end
    check("hsync_period", 32'(len), 32'(HT));

    // Vertical sync: low width and period in lines.
    seen = 1'b0;
    for (int n = 0; n < int'(VT * HT + 10); n++) begin
      tick();
      if (!V_sync) begin seen = 1'b1; break; end
    end
    check("vsync_seen", 32'(seen), 32'd1);
    len = 0;
    for (int n = 0; n < int'(VT * HT); n++) begin
      tick(); len++;
      if (V_sync) break;
    end
    check("vsync_low_width", 32'(len), 32'(VS * HT));
    for (int n = 0; n < int'(VT * HT); n++) begin
      tick(); len++;
      if (!V_sync) break;
    end
    check("vsync_period", 32'(len), 32'(VT * HT));

    // A 2 us low glitch must not produce a byte; colour order below proves idx held.
    @(negedge clk_in);
    gpio_in[16] = 1'b0;
    repeat (54) @(negedge clk_in);
    gpio_in[16] = 1'b1;
    capture(got, cap, slen, stp);
    check("glitch_no_echo", 32'(got), 32'd0);

    for (int i = 0; i < 5; i++) begin
      fork
        send_byte(vecs[i].data, vecs[i].stop);
        capture(got, cap, slen, stp);
      join
      check($sformatf("vec%0d_echo_seen", i), 32'(got), 32'(vecs[i].echo));
      if (got && vecs[i].echo) begin
        check($sformatf("vec%0d_echo_data", i), 32'(cap), 32'(vecs[i].data));
        check($sformatf("vec%0d_echo_stop", i), 32'(stp), 32'd1);
        if (vecs[i].data[0])
          check($sformatf("vec%0d_echo_bit_time", i), 32'(slen), 32'(DIV));
      end
      if (vecs[i].chk) check_colour($sformatf("vec%0d_colour", i), vecs[i].rgb);
    end

    // Two more bytes (green, blue), then reset in the middle of a third.
    send_byte(8'h70, 1'b1);
    send_byte(8'h20, 1'b1);
    @(negedge clk_in);
    gpio_in[16] = 1'b0;
    repeat (4 * DIV) @(negedge clk_in);
    erst = 1'b1;
    #1;
    check_reset_outputs("midbyte_reset");
    gpio_in[16] = 1'b1;
    repeat (20) @(negedge clk_in);
    erst = 1'b0;
    repeat (5) tick();
    check("after_reset_gpio_out", gpio_out, 32'h0002_0000);
    send_byte(8'hC0, 1'b1);
    send_byte(8'hD0, 1'b1);
    send_byte(8'hE0, 1'b1);
    check_colour("post_reset_colour", 12'hCDE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
